// File: rtl/serial_case_pkg.sv
// Shared types and limits for the serial case-statement evaluator.
// Item kinds describe how each case label produces its match value.
package serial_case_pkg;

  localparam int MAX_ITEMS = 16;
  localparam int IDX_W     = 4;

  typedef enum logic [0:0] {
    IK_TMP_POSTINC,
    IK_CONST
  } item_kind_e;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_e;

  // Wrapping post-increment of the temporary, modulo 2^W.
  function automatic logic [31:0] wrap_inc(input logic [31:0] value, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/serial_case_matcher_select.sv
// Combinational per-item lookup: match value, increment enable, answer and
// last-item flag for the case item currently addressed by idx.
module case_item_select
  import serial_case_pkg::*;
#(
  parameter int                W          = 4,
  parameter int                NITEMS     = 2,
  parameter item_kind_e        ITEM_KIND  [MAX_ITEMS] = '{0: IK_TMP_POSTINC, default: IK_CONST},
  parameter logic [W-1:0]      ITEM_CONST [MAX_ITEMS] = '{default: '0},
  parameter logic [31:0]       ITEM_ANS   [MAX_ITEMS] = '{0: 32'd1, 1: 32'd2, default: 32'd0}
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [W-1:0]     tmp,
  output logic [W-1:0]     mv,
  output logic             inc_en,
  output logic [W-1:0]     tmp_next,
  output logic [31:0]      ans,
  output logic             last
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mv       = ITEM_CONST[idx];
    inc_en   = 1'b0;
    tmp_next = tmp;
    if (ITEM_KIND[idx] == IK_TMP_POSTINC) begin
      mv       = tmp;
      inc_en   = 1'b1;
      tmp_next = tmp + W'(1);
    end
  end

  assign ans  = ITEM_ANS[idx];
  assign last = (idx == IDX_W'(NITEMS - 1));

endmodule

// File: rtl/serial_case_matcher.sv
// Evaluates a priority case one item per clock, stopping at the first match;
// a post-increment item commits its side effect exactly once when evaluated.
module serial_case_matcher
  import serial_case_pkg::*;
#(
  parameter int           W           = 4,
  parameter int           NITEMS      = 2,
  parameter item_kind_e   ITEM_KIND   [MAX_ITEMS] = '{0: IK_TMP_POSTINC, default: IK_CONST},
  parameter logic [W-1:0] ITEM_CONST  [MAX_ITEMS] = '{default: '0},
  parameter logic [31:0]  ITEM_ANS    [MAX_ITEMS] = '{0: 32'd1, 1: 32'd2, default: 32'd0},
  parameter logic [31:0]  DEFAULT_ANS = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ans,
  output logic [W-1:0]     out_tmp,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_idx
);

  state_e             state;
  logic [W-1:0]       a;
  logic [W-1:0]       tmp;
  logic [IDX_W-1:0]   idx;

  logic [W-1:0]       mv;
  logic               inc_en;
  logic [W-1:0]       tmp_next;
  logic [31:0]        item_ans;
  logic               item_last;

  case_item_select #(
    .W          (W),
    .NITEMS     (NITEMS),
    .ITEM_KIND  (ITEM_KIND),
    .ITEM_CONST (ITEM_CONST),
    .ITEM_ANS   (ITEM_ANS)
  ) u_select (
    .idx      (idx),
    .tmp      (tmp),
    .mv       (mv),
    .inc_en   (inc_en),
    .tmp_next (tmp_next),
    .ans      (item_ans),
    .last     (item_last)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and ordering inside the block is irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_ans   <= '0;
      out_tmp   <= '0;
      out_hit   <= 1'b0;
      out_idx   <= '0;
      a         <= '0;
      tmp       <= '0;
      idx       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a        <= in_a;
            tmp      <= in_b;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= EVAL;
          end
        end

        EVAL: begin
          // The old tmp is compared while the increment still commits.
          if (inc_en) tmp <= tmp_next;
          if (a == mv) begin
            out_ans   <= item_ans;
            out_hit   <= 1'b1;
            out_idx   <= idx;
            out_tmp   <= tmp_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (item_last) begin
            out_ans   <= DEFAULT_ANS;
            out_hit   <= 1'b0;
            out_idx   <= '0;
            out_tmp   <= tmp_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_case_matcher.sv
// Directed bench for serial_case_matcher: a loop-based model of the case
// statement predicts each result; a negedge monitor compares every valid cycle.
module tb_serial_case_matcher;
  import serial_case_pkg::*;

  localparam int W  = 4;
  localparam int NI = 2;

  // Bench-side description of the case statement: item 0 is tmp++, item 1 is 0.
  localparam bit          M_IS_INC [NI] = '{1'b1, 1'b0};
  localparam int          M_CONST  [NI] = '{0, 0};
  localparam int          M_ANS    [NI] = '{1, 2};
  localparam int          M_DEF    = 0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_ans;
  logic [W-1:0] out_tmp;
  logic         out_hit;
  logic [3:0]   out_idx;

  int checks = 0;
  int failures = 0;

  // Expectation for the in-flight request, shared with the monitor.
  bit pending = 0;
  bit seen = 0;
  int lat_cnt = 0;
  int exp_ans, exp_tmp, exp_hit, exp_idx, exp_lat;

  serial_case_matcher #(.W(W), .NITEMS(NI)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ans   (out_ans),
    .out_tmp   (out_tmp),
    .out_hit   (out_hit),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Walk the items in order; first match wins, post-increment always commits.
  task automatic model(input int a, input int b,
                       output int ans, output int tmp, output int hit, output int idx, output int lat);
    int t, mv, evals;
    t = b; ans = M_DEF; hit = 0; idx = 0; evals = 0;
    for (int i = 0; i < NI; i++) begin
      evals = i + 1;
      if (M_IS_INC[i]) begin
        mv = t;
        t = (t + 1) % (1 << W);
      end else begin
        mv = M_CONST[i];
      end
      if (a == mv) begin
        ans = M_ANS[i]; hit = 1; idx = i;
        break;
      end
    end
    tmp = t;
    lat = evals + 1;
  endtask

  // Monitor: compares outputs on every cycle they are meaningful.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pending) lat_cnt++;
      if (!pending) begin
        check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      end else begin
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        if (out_valid) begin
          if (!seen) begin
            check("latency", lat_cnt, exp_lat);
            seen = 1;
          end
          check("out_ans", out_ans, exp_ans);
          check("out_tmp", {28'd0, out_tmp}, exp_tmp);
          check("out_hit", {31'd0, out_hit}, exp_hit);
          check("out_idx", {28'd0, out_idx}, exp_idx);
          if (out_ready) pending = 0;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // Drive one request; hold_cycles>0 stalls out_ready while spamming in_valid.
  task automatic run_txn(input int a, input int b, input int l_ans, input int l_tmp,
                         input int l_hit, input int l_idx, input int l_lat, input int hold_cycles);
    int m_ans, m_tmp, m_hit, m_idx, m_lat, n;
    model(a, b, m_ans, m_tmp, m_hit, m_idx, m_lat);
    check("model_ans", m_ans, l_ans);
    check("model_tmp", m_tmp, l_tmp);
    check("model_hit", m_hit, l_hit);
    check("model_idx", m_idx, l_idx);
    check("model_lat", m_lat, l_lat);
    wait_ready();
    out_ready = (hold_cycles == 0);
    in_valid = 1'b1;
    in_a = W'(a);
    in_b = W'(b);
    @(posedge clk);
    exp_ans = m_ans; exp_tmp = m_tmp; exp_hit = m_hit; exp_idx = m_idx; exp_lat = m_lat;
    lat_cnt = 0; seen = 0; pending = 1;
    #1;
    in_valid = 1'b0;
    in_a = ~W'(a);
    in_b = W'(b + 7);
    if (hold_cycles > 0) begin
      n = 0;
      while (!seen && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("result_wait", {31'd0, seen}, 32'd1);
      for (int i = 0; i < hold_cycles; i++) begin
        in_valid = 1'b1;
        in_a = W'(i + 3);
        in_b = W'(i * 5);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    n = 0;
    while (pending && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("handshake_wait", {31'd0, pending}, 32'd0);
  endtask

  initial begin
    #7;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_ans", out_ans, 32'd0);
    check("rst_out_tmp", {28'd0, out_tmp}, 32'd0);
    check("rst_out_hit", {31'd0, out_hit}, 32'd0);
    check("rst_out_idx", {28'd0, out_idx}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    //       a   b  ans tmp hit idx lat hold
    run_txn( 5,  5,  1,  6,  1,  0,  2,  0);  // item 0 match
    run_txn( 0,  3,  2,  4,  1,  1,  3,  0);  // item 1 const match
    run_txn( 0,  0,  1,  1,  1,  0,  2,  0);  // priority over later match
    run_txn( 7,  3,  0,  4,  0,  0,  3,  0);  // no match
    run_txn(15, 15,  1,  0,  1,  0,  2,  0);  // wrap-around
    run_txn( 4,  9,  0, 10,  0,  0,  3,  5);  // stalled consumer
    run_txn( 9,  9,  1, 10,  1,  0,  2,  0);

    // Reset mid-EVAL: request dropped, outputs cleared at once.
    wait_ready();
    in_valid = 1'b1; in_a = 4'd0; in_b = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_ans", out_ans, 32'd0);
    check("mid_rst_out_tmp", {28'd0, out_tmp}, 32'd0);
    check("mid_rst_out_hit", {31'd0, out_hit}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    run_txn( 3,  3,  1,  4,  1,  0,  2,  0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
